// File: rtl/la_prbs.sv
// PRBS7/9/15/31 generator and self-synchronising checker with lock tracking and saturating error count.
// la_prbs_xor4 models the stdlib 4-input XOR cell that supplies the feedback and compare terms.

module la_prbs_xor4 #(
    parameter PROP = "DEFAULT"
) (
    input  logic [3:0] a_i,
    output logic       y_o
);
    if (PROP == "DEFAULT") begin : g_flat
        assign y_o = ^a_i;
    end else begin : g_tree
        assign y_o = (a_i[0] ^ a_i[1]) ^ (a_i[2] ^ a_i[3]);
    end
endmodule

// state | meaning
// HUNT  | checker register loads received bits, counting consecutive predicted matches
// LOCK  | checker free-runs on its own prediction, counting and flagging mismatches
module la_prbs #(
    parameter     PROP    = "DEFAULT",
    parameter int CW      = 16,
    parameter int LOCKCNT = 40,
    parameter int LOSSCNT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic          en,
    output logic          gen_out,
    input  logic          chk_in,
    input  logic          chk_valid,
    input  logic          err_clr,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_cnt
);
    localparam int             MW         = $clog2(LOCKCNT + 1);
    localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCKCNT - 1);
    localparam logic [7:0]     MISS_LAST  = 8'(LOSSCNT - 1);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t        state_q;
    logic [1:0]    mode_q;
    logic [30:0]   s_q;
    logic [30:0]   c_q;
    logic          gen_q;
    logic [MW-1:0] match_q;
    logic [7:0]    miss_q;
    logic          locked_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic [MW-1:0] match_d;
    logic [7:0]    miss_d;
    logic [CW-1:0] cnt_d;

    logic        s_hi, s_lo, c_hi, c_lo;
    logic [30:0] c_mask;
    logic        gen_fb, pred, mism, c_nz;

    always_comb begin
        s_hi   = s_q[6];
        s_lo   = s_q[5];
        c_hi   = c_q[6];
        c_lo   = c_q[5];
        c_mask = 31'h0000_007F;
        case (mode_q)
            2'd1: begin
                s_hi   = s_q[8];
                s_lo   = s_q[4];
                c_hi   = c_q[8];
                c_lo   = c_q[4];
                c_mask = 31'h0000_01FF;
            end
            2'd2: begin
                s_hi   = s_q[14];
                s_lo   = s_q[13];
                c_hi   = c_q[14];
                c_lo   = c_q[13];
                c_mask = 31'h0000_7FFF;
            end
            2'd3: begin
                s_hi   = s_q[30];
                s_lo   = s_q[27];
                c_hi   = c_q[30];
                c_lo   = c_q[27];
                c_mask = 31'h7FFF_FFFF;
            end
            default: ;
        endcase
    end

    la_prbs_xor4 #(.PROP(PROP)) u_gen_fb (.a_i({2'b00, s_hi, s_lo}), .y_o(gen_fb));
    la_prbs_xor4 #(.PROP(PROP)) u_pred   (.a_i({2'b00, c_hi, c_lo}), .y_o(pred));
    la_prbs_xor4 #(.PROP(PROP)) u_cmp    (.a_i({1'b0, c_hi, c_lo, chk_in}), .y_o(mism));

    // The all-zero guard keeps a stuck-at-0 line from looking like a perfect match.
    assign c_nz    = |(c_q & c_mask);
    assign match_d = match_q + 1'b1;
    assign miss_d  = miss_q + 1'b1;
    assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            mode_q   <= mode;
            s_q      <= '1;
            c_q      <= '0;
            gen_q    <= 1'b0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (err_clr) begin
                cnt_q <= '0;
            end
            if (mode != mode_q) begin
                mode_q   <= mode;
                s_q      <= '1;
                c_q      <= '0;
                state_q  <= HUNT;
                locked_q <= 1'b0;
                match_q  <= '0;
                miss_q   <= '0;
            end else begin
                if (en) begin
                    s_q   <= {s_q[29:0], gen_fb};
                    gen_q <= gen_fb;
                end
                if (chk_valid) begin
                    case (state_q)
                        HUNT: begin
                            c_q <= {c_q[29:0], chk_in};
                            if (!mism && c_nz) begin
                                match_q <= match_d;
                                if (match_q == MATCH_LAST) begin
                                    state_q  <= LOCK;
                                    locked_q <= 1'b1;
                                    miss_q   <= '0;
                                end
                            end else begin
                                match_q <= '0;
                            end
                        end
                        LOCK: begin
                            // Shift the prediction, not the input, so one bad bit counts once.
                            c_q <= {c_q[29:0], pred};
                            if (mism) begin
                                err_q <= 1'b1;
                                if (!err_clr) begin
                                    cnt_q <= cnt_d;
                                end
                                if (miss_q == MISS_LAST) begin
                                    state_q  <= HUNT;
                                    locked_q <= 1'b0;
                                    match_q  <= '0;
                                    miss_q   <= '0;
                                end else begin
                                    miss_q <= miss_d;
                                end
                            end else begin
                                miss_q <= '0;
                            end
                        end
                        default: state_q <= HUNT;
                    endcase
                end
            end
        end
    end

    assign gen_out = gen_q;
    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_la_prbs.sv
// Scoreboard bench for la_prbs: expected generator bits and error-count values are queued by the
// driver and popped by a monitor whenever the DUT produces a generator bit or an err pulse.

module tb_la_prbs;
    localparam int LOCKCNT = 40;
    localparam int LOSSCNT = 8;
    localparam int LOCK_BUDGET = LOCKCNT + 31 + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, err_clr, inv, force0;
    logic [1:0]  mode;
    logic        chk_in, chk_valid;
    logic        gen_out, locked, err;
    logic [15:0] err_cnt;
    logic        gen_out4, locked4, err4;
    logic [3:0]  err_cnt4;

    assign chk_in    = force0 ? 1'b0 : (gen_out ^ inv);
    assign chk_valid = en;

    la_prbs #(.PROP("DEFAULT"), .CW(16), .LOCKCNT(LOCKCNT), .LOSSCNT(LOSSCNT)) dut (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .gen_out(gen_out),
        .chk_in(chk_in), .chk_valid(chk_valid), .err_clr(err_clr),
        .locked(locked), .err(err), .err_cnt(err_cnt));

    la_prbs #(.PROP("DEFAULT"), .CW(4), .LOCKCNT(LOCKCNT), .LOSSCNT(LOSSCNT)) dut4 (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .gen_out(gen_out4),
        .chk_in(chk_in), .chk_valid(chk_valid), .err_clr(err_clr),
        .locked(locked4), .err(err4), .err_cnt(err_cnt4));

    typedef struct packed {
        logic [15:0] m;
        logic [3:0]  s;
    } errexp_t;

    int      n_checks = 0;
    int      n_errors = 0;
    bit      exp_gen_q[$];
    errexp_t exp_err_q[$];
    logic    gen_track = 1'b0;
    logic    gen_tag = 1'b0;
    int      mcnt = 0;
    int      scnt = 0;
    bit      hist[$];
    int      deg = 7;
    int      tap = 6;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) gen_tag <= en & gen_track & ~reset;

    always @(negedge clk) begin : monitor
        bit      b;
        errexp_t e;
        if (gen_tag) begin
            if (exp_gen_q.size() == 0) begin
                check("gen_unexpected", 32'(exp_gen_q.size()), 1);
            end else begin
                b = exp_gen_q.pop_front();
                check("gen_out", 32'(gen_out), 32'(b));
                check("gen_out_cw4", 32'(gen_out4), 32'(b));
            end
        end
        if (err || err4) begin
            if (exp_err_q.size() == 0) begin
                check("err_unexpected", 32'(err_cnt), 32'hFFFF_FFFF);
            end else begin
                e = exp_err_q.pop_front();
                check("err_pulse", 32'(err), 1);
                check("err_pulse_cw4", 32'(err4), 1);
                check("err_cnt", 32'(err_cnt), 32'(e.m));
                check("err_cnt_cw4", 32'(err_cnt4), 32'(e.s));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_seed(input int d, input int t);
        hist.delete();
        for (int i = 0; i < 31; i++) hist.push_back(1'b1);
        deg = d;
        tap = t;
    endtask

    // Bit-history form of the recurrence: b[n] = b[n-deg] ^ b[n-tap], seed history all ones.
    task automatic ref_next(output bit nb);
        nb = hist[hist.size() - deg] ^ hist[hist.size() - tap];
        hist.push_back(nb);
    endtask

    task automatic wait_lock(input int budget, input string nm);
        int vb = 0;
        while (!locked && vb < budget) begin
            en = 1'b1;
            tick();
            vb++;
        end
        en = 1'b0;
        check(nm, 32'(locked), 1);
    endtask

    task automatic soak(input int nbits);
        int v = 0;
        while (v < nbits) begin
            en = ($urandom_range(3) != 0);
            if (en) v++;
            tick();
        end
        en = 1'b0;
        check("soak_err_cnt", 32'(err_cnt), 0);
        check("soak_locked", 32'(locked), 1);
    endtask

    task automatic inject(input bit clr);
        errexp_t e;
        if (clr) begin
            mcnt = 0;
            scnt = 0;
        end else begin
            mcnt++;
            if (scnt < 15) scnt++;
        end
        e.m = 16'(mcnt);
        e.s = 4'(scnt);
        exp_err_q.push_back(e);
        en = 1'b1;
        inv = 1'b1;
        err_clr = clr;
        tick();
        inv = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        bit first7 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit nb;
        int idx;
        int nlocked;

        reset = 1'b1; mode = 2'd0; en = 1'b0; err_clr = 1'b0; inv = 1'b0; force0 = 1'b0;
        repeat (3) tick();
        check("rst_gen_out", 32'(gen_out), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        // PRBS7 generator: hand values for bits 0..6 and again one period later.
        reset = 1'b0;
        ref_seed(7, 6);
        gen_track = 1'b1;
        idx = 0;
        for (int i = 0; i < 300; i++) begin
            en = (i < 7) ? 1'b1 : (i % 3 != 2);
            if (en) begin
                ref_next(nb);
                if (idx < 7) exp_gen_q.push_back(first7[idx]);
                else if (idx >= 127 && idx < 134) exp_gen_q.push_back(first7[idx - 127]);
                else exp_gen_q.push_back(nb);
                idx++;
            end
            tick();
        end
        en = 1'b0;
        gen_track = 1'b0;
        check("lock_prbs7", 32'(locked), 1);
        soak(2500);

        for (int m = 1; m <= 3; m++) begin
            mode = 2'(m);
            en = 1'b0;
            tick();
            check("locked_after_mode", 32'(locked), 0);
            check("locked_after_mode_cw4", 32'(locked4), 0);
            if (m == 3) begin
                // PRBS31 from the all-ones seed: 28 zeros, then a one.
                gen_track = 1'b1;
                for (int i = 0; i < 29; i++) begin
                    en = 1'b1;
                    exp_gen_q.push_back(i == 28);
                    tick();
                end
                gen_track = 1'b0;
                wait_lock(LOCK_BUDGET - 29, "lock_mode");
            end else begin
                wait_lock(LOCK_BUDGET, "lock_mode");
            end
            soak((m == 3) ? 10000 : 2500);
        end

        inject(1'b0);
        en = 1'b1;
        repeat (3) tick();
        check("single_err_locked", 32'(locked), 1);
        check("single_err_cnt", 32'(err_cnt), 1);

        for (int k = 0; k < LOSSCNT; k++) begin
            inject(1'b0);
            if (k == LOSSCNT - 2) check("locked_before_last_miss", 32'(locked), 1);
            if (k == LOSSCNT - 1) begin
                check("lock_drop", 32'(locked), 0);
                check("lock_drop_cw4", 32'(locked4), 0);
            end
        end
        check("burst_err_cnt", 32'(err_cnt), 9);
        wait_lock(LOCK_BUDGET, "relock_after_burst");

        for (int k = 0; k < 11; k++) begin
            inject(1'b0);
            en = 1'b1;
            repeat (2) tick();
        end
        check("sat_err_cnt16", 32'(err_cnt), 20);
        check("sat_err_cnt4", 32'(err_cnt4), 15);
        check("sat_locked", 32'(locked), 1);
        inject(1'b1);
        check("clr_err_cnt", 32'(err_cnt), 0);
        check("clr_err_cnt4", 32'(err_cnt4), 0);

        inject(1'b0);
        en = 1'b1;
        repeat (2) tick();
        // Reset wins over a mode change and a mismatch at the same edge.
        mode = 2'd1; inv = 1'b1; en = 1'b1; reset = 1'b1;
        tick();
        mcnt = 0; scnt = 0;
        check("midrst_gen_out", 32'(gen_out), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_err_cnt", 32'(err_cnt), 0);
        check("midrst_err_cnt4", 32'(err_cnt4), 0);
        inv = 1'b0; reset = 1'b0; en = 1'b0;
        tick();

        force0 = 1'b1;
        nlocked = 0;
        en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (locked) nlocked++;
        end
        en = 1'b0;
        force0 = 1'b0;
        check("stuck0_locked_cycles", 32'(nlocked), 0);
        check("stuck0_err_cnt", 32'(err_cnt), 0);
        wait_lock(LOCK_BUDGET, "relock_after_reset");

        tick();
        check("err_queue_drained", 32'(exp_err_q.size()), 0);
        check("gen_queue_drained", 32'(exp_gen_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
